// File: rtl/sup_counter_sched_pkg.sv
// Shared definitions for the two-requester counter scheduler: FSM encoding and requester IDs.
package sup_counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/sup_counter_sched_if.sv
// Request/grant/counter bundle between the requesters and sup_counter_sched.
// The abort/aborted pair exists only when SUP_COUNTER_SCHED_ABORT_EN is defined.
interface sup_counter_sched_if #(parameter int WIDTH = 4);

    logic             req0;
    logic [WIDTH-1:0] len0;
    logic             req1;
    logic [WIDTH-1:0] len1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic [WIDTH-1:0] o;
    logic             done;
    logic             done_id;
`ifdef SUP_COUNTER_SCHED_ABORT_EN
    logic             abort;
    logic             aborted;

    modport slave (
        input  req0, len0, req1, len1, abort,
        output gnt0, gnt1, busy, o, done, done_id, aborted
    );

    modport master (
        output req0, len0, req1, len1, abort,
        input  gnt0, gnt1, busy, o, done, done_id, aborted
    );
`else
    modport slave (
        input  req0, len0, req1, len1,
        output gnt0, gnt1, busy, o, done, done_id
    );

    modport master (
        output req0, len0, req1, len1,
        input  gnt0, gnt1, busy, o, done, done_id
    );
`endif

endinterface

// File: rtl/sup_counter_rr_arb.sv
// Two-way round-robin pick with a last-grant pointer; pointer resets to REQ1 so REQ0 wins the first tie.
module sup_counter_rr_arb
    import sup_counter_sched_pkg::*;
(
    input  logic cl,
    input  logic r,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic valid,
    output logic winner
);

    logic last;

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req0) begin
            winner = REQ0;
        end else begin
            winner = REQ1;
        end
    end

    // Pointer only moves when the scheduler actually accepts the pick.
    always_ff @(posedge cl or negedge r) begin
        if (!r) begin
            last <= REQ1;
        end else if (take && valid) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/sup_counter_sched.sv
// Shares one up-counter between two requesters: arbitrate, count 0..len-1, pulse done, release.
// Optional abort support is enabled by defining SUP_COUNTER_SCHED_ABORT_EN.
module sup_counter_sched
    import sup_counter_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                cl,
    input logic                r,
    sup_counter_sched_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic             owner;
    logic [WIDTH-1:0] len_lat;
    logic [WIDTH-1:0] owner_len;
    logic [WIDTH-1:0] o_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;
    logic             pick_valid;
    logic             pick_id;
    logic             abort_req;

    assign owner_len = (owner == REQ1) ? bus.len1 : bus.len0;

`ifdef SUP_COUNTER_SCHED_ABORT_EN
    logic aborted_q;

    assign abort_req = bus.abort;

    // High only during the DONE cycle that an abort produced.
    always_ff @(posedge cl or negedge r) begin
        if (!r) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= bus.abort && (state == GRANT || state == RUN);
        end
    end

    assign bus.aborted = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    sup_counter_rr_arb u_arb (
        .cl     (cl),
        .r      (r),
        .req0   (bus.req0),
        .req1   (bus.req1),
        .take   (state == IDLE),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_ff @(posedge cl or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            owner     <= REQ0;
            o_q       <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= REQ0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state  <= GRANT;
                        owner  <= pick_id;
                        gnt0_q <= (pick_id == REQ0);
                        gnt1_q <= (pick_id == REQ1);
                        busy_q <= 1'b1;
                        o_q    <= '0;
                    end
                end
                GRANT: begin
                    if (abort_req || owner_len == '0) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        done_id_q <= owner;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The last count is held through DONE, so o never wraps.
                    if (abort_req || o_q == len_lat - ONE) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        done_id_q <= owner;
                    end else begin
                        o_q <= o_q + ONE;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    busy_q <= 1'b0;
                    o_q    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Run length is captured once in GRANT; later len changes have no effect.
    always_ff @(posedge cl) begin
        if (state == GRANT) begin
            len_lat <= owner_len;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.o       = o_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_sup_counter_sched.sv
// Bench for sup_counter_sched: cycle table, directed corner sequences and random traffic vs a run-timeline model.
module tb_sup_counter_sched;
    import sup_counter_sched_pkg::*;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic             gnt0;
        logic             gnt1;
        logic             busy;
        logic             done;
        logic             done_id;
        logic             aborted;
        logic [WIDTH-1:0] o;
    } obs_t;

    typedef struct {
        logic             req0;
        logic [WIDTH-1:0] len0;
        logic             req1;
        logic [WIDTH-1:0] len1;
        obs_t             exp;
    } vec_t;

    logic             cl = 1'b0;
    logic             r = 1'b0;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] len0 = '0;
    logic [WIDTH-1:0] len1 = '0;
    logic             abort_in = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    // Model: a run is a timeline of len+2 owned cycles (index 0 = grant, last = done).
    logic m_active, m_owner, m_last, m_done_id, m_ab;
    int   m_k, m_end;

    always #5 cl = ~cl;

    sup_counter_sched_if #(.WIDTH(WIDTH)) bus ();

    assign bus.req0 = req0;
    assign bus.req1 = req1;
    assign bus.len0 = len0;
    assign bus.len1 = len1;
`ifdef SUP_COUNTER_SCHED_ABORT_EN
    assign bus.abort = abort_in;
`endif

    sup_counter_sched #(.WIDTH(WIDTH)) dut (
        .cl  (cl),
        .r   (r),
        .bus (bus)
    );

    function automatic obs_t observe();
        obs_t a;
        a.gnt0    = bus.gnt0;
        a.gnt1    = bus.gnt1;
        a.busy    = bus.busy;
        a.done    = bus.done;
        a.done_id = bus.done_id;
`ifdef SUP_COUNTER_SCHED_ABORT_EN
        a.aborted = bus.aborted;
`else
        a.aborted = 1'b0;
`endif
        a.o       = bus.o;
        return a;
    endfunction

    function automatic obs_t mk(logic g0, logic g1, logic b, logic d, logic id, int o);
        obs_t e;
        e.gnt0 = g0; e.gnt1 = g1; e.busy = b; e.done = d; e.done_id = id;
        e.aborted = 1'b0; e.o = WIDTH'(o);
        return e;
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = observe();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got g0=%b g1=%b busy=%b done=%b id=%b ab=%b o=%0d want g0=%b g1=%b busy=%b done=%b id=%b ab=%b o=%0d",
                     name, $time, act.gnt0, act.gnt1, act.busy, act.done, act.done_id, act.aborted, act.o,
                     exp.gnt0, exp.gnt1, exp.busy, exp.done, exp.done_id, exp.aborted, exp.o);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
        end
    endtask

    function automatic obs_t model_out();
        obs_t e;
        e = '0;
        e.done_id = m_done_id;
        if (m_active) begin
            e.busy = 1'b1;
            e.gnt0 = (m_owner == REQ0);
            e.gnt1 = (m_owner == REQ1);
            if (m_k == 0) begin
                e.o = '0;
            end else if (m_k < m_end) begin
                e.o = WIDTH'(m_k - 1);
            end else begin
                e.o       = (m_end < 2) ? '0 : WIDTH'(m_end - 2);
                e.done    = 1'b1;
                e.done_id = m_owner;
                e.aborted = m_ab;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_owner = REQ0; m_last = REQ1; m_done_id = REQ0;
        m_ab = 1'b0; m_k = 0; m_end = 1;
    endtask

    // Advances the model across one edge using the inputs currently applied.
    task automatic model_step();
        if (!m_active) begin
            if (req0 || req1) begin
                m_owner  = (req0 && req1) ? ~m_last : (req0 ? REQ0 : REQ1);
                m_last   = m_owner;
                m_active = 1'b1;
                m_k      = 0;
                m_ab     = 1'b0;
            end
        end else if (m_k == 0) begin
            m_ab  = abort_in;
            m_end = abort_in ? 1 : ((m_owner == REQ0) ? int'(len0) : int'(len1)) + 1;
            m_k   = 1;
        end else if (m_k == m_end) begin
            m_active  = 1'b0;
            m_done_id = m_owner;
        end else begin
            if (abort_in) begin
                m_end = m_k + 1;
                m_ab  = 1'b1;
            end
            m_k++;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge cl);
        @(negedge cl);
        check_obs("model", model_out());
    endtask

    task automatic do_reset();
        r = 1'b0; req0 = 1'b0; req1 = 1'b0; abort_in = 1'b0;
        #1;
        check_obs("reset", '0);
        model_reset();
        @(negedge cl);
        r = 1'b1;
    endtask

    initial begin
        vec_t tbl[10];
        int   order[$];
        logic p0, p1;
        int   gcnt;

        tbl[0] = '{1'b1, 4'd3, 1'b0, 4'd0, mk(1, 0, 1, 0, 0, 0)};
        tbl[1] = '{1'b0, 4'd3, 1'b0, 4'd0, mk(1, 0, 1, 0, 0, 0)};
        tbl[2] = '{1'b0, 4'd3, 1'b0, 4'd0, mk(1, 0, 1, 0, 0, 1)};
        tbl[3] = '{1'b0, 4'd3, 1'b0, 4'd0, mk(1, 0, 1, 0, 0, 2)};
        tbl[4] = '{1'b0, 4'd3, 1'b0, 4'd0, mk(1, 0, 1, 1, 0, 2)};
        tbl[5] = '{1'b0, 4'd0, 1'b1, 4'd0, mk(0, 0, 0, 0, 0, 0)};
        tbl[6] = '{1'b0, 4'd0, 1'b1, 4'd0, mk(0, 1, 1, 0, 0, 0)};
        tbl[7] = '{1'b0, 4'd0, 1'b0, 4'd0, mk(0, 1, 1, 1, 1, 0)};
        tbl[8] = '{1'b0, 4'd0, 1'b0, 4'd0, mk(0, 0, 0, 0, 1, 0)};
        tbl[9] = '{1'b0, 4'd0, 1'b0, 4'd0, mk(0, 0, 0, 0, 1, 0)};

        @(negedge cl);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            req0 = tbl[i].req0; len0 = tbl[i].len0;
            req1 = tbl[i].req1; len1 = tbl[i].len1;
            cycle();
            check_obs($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Both requesting from reset: grants alternate starting with requester 0.
        @(negedge cl);
        do_reset();
        req0 = 1'b1; req1 = 1'b1; len0 = 4'd2; len1 = 4'd2;
        p0 = 1'b0; p1 = 1'b0;
        for (int n = 0; n < 22; n++) begin
            cycle();
            if (bus.gnt0 && !p0) order.push_back(0);
            if (bus.gnt1 && !p1) order.push_back(1);
            p0 = bus.gnt0; p1 = bus.gnt1;
        end
        check_int("rr_grant_count", (order.size() >= 4) ? 4 : order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            check_int($sformatf("rr_order[%0d]", i), order[i], i % 2);

        // Full-length run with len changed mid-run.
        req0 = 1'b0; req1 = 1'b0;
        for (int n = 0; n < 10 && bus.busy; n++) cycle();
        check_int("idle_before_len15", int'(bus.busy), 0);
        req0 = 1'b1; len0 = 4'd15;
        cycle();
        gcnt = bus.gnt0 ? 1 : 0;
        req0 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycle();
            if (bus.gnt0) gcnt++;
        end
        len0 = 4'd5;
        for (int n = 0; n < 30 && !bus.done; n++) begin
            cycle();
            if (bus.gnt0) gcnt++;
        end
        check_int("len15_done", int'(bus.done), 1);
        check_int("len15_final_o", int'(bus.o), 14);
        check_int("len15_gnt_cycles", gcnt, 17);
        cycle();

        // Asynchronous reset in the middle of a run.
        req0 = 1'b1; len0 = 4'd10;
        cycle();
        req0 = 1'b0;
        for (int n = 0; n < 20 && !(bus.busy && bus.o == 4'd4); n++) cycle();
        check_int("reach_o4", int'(bus.busy && bus.o == 4'd4), 1);
        #2 r = 1'b0;
        #1 check_obs("async_rst", '0);
        model_reset();
        @(negedge cl);
        r = 1'b1;
        req0 = 1'b1; len0 = 4'd1;
        cycle();
        check_int("post_rst_gnt0", int'(bus.gnt0), 1);
        req0 = 1'b0;
        for (int n = 0; n < 4; n++) cycle();

`ifdef SUP_COUNTER_SCHED_ABORT_EN
        @(negedge cl);
        do_reset();
        req0 = 1'b1; len0 = 4'd10;
        cycle();
        req0 = 1'b0; req1 = 1'b1; len1 = 4'd1;
        for (int n = 0; n < 20 && !(bus.gnt0 && bus.o == 4'd3); n++) cycle();
        check_int("reach_o3", int'(bus.gnt0 && bus.o == 4'd3), 1);
        abort_in = 1'b1;
        cycle();
        abort_in = 1'b0;
        check_obs("abort_done", '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3});
        cycle();
        cycle();
        check_int("abort_then_gnt1", int'(bus.gnt1), 1);
        req1 = 1'b0;
        for (int n = 0; n < 4; n++) cycle();
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            len0 = WIDTH'($urandom_range(0, 6));
            len1 = WIDTH'($urandom_range(0, 6));
`ifdef SUP_COUNTER_SCHED_ABORT_EN
            abort_in = ($urandom_range(0, 15) == 0);
`endif
            cycle();
            n_tests++;
            if (bus.gnt0 && bus.gnt1) begin
                n_fail++;
                $display("FAIL gnt_exclusive t=%0t got gnt0=%b gnt1=%b want not both", $time, bus.gnt0, bus.gnt1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got no finish want finish before limit", $time);
        $fatal(1, "watchdog");
    end

endmodule
